// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression-loop controller: latches the chaining value, runs 64 rounds
// gated by a Wt valid/ready handshake, then folds the working variables back into H.
module usigma0 (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);
  assign o_y = {i_x[1:0], i_x[31:2]} ^ {i_x[12:0], i_x[31:13]} ^ {i_x[21:0], i_x[31:22]};
endmodule

module usigma1 (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);
  assign o_y = {i_x[5:0], i_x[31:6]} ^ {i_x[10:0], i_x[31:11]} ^ {i_x[24:0], i_x[31:25]};
endmodule

module sha256_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_t;
  logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [255:0]  r_hin;
  logic [255:0]  r_hash_out;
  logic          r_done;

  logic [31:0]   w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;
  logic          w_fire;

  usigma0 u_sig0 (.i_x(r_a), .o_y(w_sig0));
  usigma1 u_sig1 (.i_x(r_e), .o_y(w_sig1));

  assign w_ch   = (r_e & r_f) ^ (~r_e & r_g);
  assign w_maj  = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
  assign w_t1   = r_h + w_sig1 + w_ch + K_ROM[r_t] + w_data;
  assign w_t2   = w_sig0 + w_maj;
  assign w_fire = w_valid && (r_state == S_ROUND);

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ROUND;
      S_ROUND: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_fire && (r_t == 6'd63)) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign done     = r_done;
  assign hash_out = r_hash_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      r_hin      <= '0;
      r_hash_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_hin <= hash_in;
          {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= hash_in;
          r_t   <= '0;
        end
        S_ROUND: if (w_fire) begin
          r_h <= r_g;
          r_g <= r_f;
          r_f <= r_e;
          r_e <= r_d + w_t1;
          r_d <= r_c;
          r_c <= r_b;
          r_b <= r_a;
          r_a <= w_t1 + w_t2;
          r_t <= r_t + 6'd1;  // wraps to 0 on the last round
        end
        S_FINAL: begin
          r_hash_out <= {r_hin[255:224] + r_a, r_hin[223:192] + r_b,
                         r_hin[191:160] + r_c, r_hin[159:128] + r_d,
                         r_hin[127:96]  + r_e, r_hin[95:64]   + r_f,
                         r_hin[63:32]   + r_g, r_hin[31:0]    + r_h};
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: a software compression model predicts each
// digest when start is driven; the prediction is popped and compared on done.
module tb_sha256_round_ctrl;
  logic         clk = 1'b0;
  logic         rst, start, w_valid;
  logic [255:0] hash_in;
  logic [31:0]  w_data;
  logic         w_ready, busy, done;
  logic [255:0] hash_out;

  sha256_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .hash_in(hash_in),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .busy(busy), .done(done), .hash_out(hash_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] sb_q[$];
  logic [31:0]  wsched[64];

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_block(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) wsched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(wsched[i-15], 7) ^ rotr(wsched[i-15], 18) ^ (wsched[i-15] >> 3);
      s1 = rotr(wsched[i-2], 17) ^ rotr(wsched[i-2], 19) ^ (wsched[i-2] >> 10);
      wsched[i] = s1 + wsched[i-7] + s0 + wsched[i-16];
    end
  endtask

  function automatic logic [255:0] compress(input logic [255:0] hv);
    logic [31:0]  v[8];
    logic [31:0]  t1, t2, bs0, bs1;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      bs1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      bs0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t1 = v[7] + bs1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + wsched[r];
      t2 = bs0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  // Called at a sample point (#1 after a rising edge). Drives start, then feeds Wt
  // until done, a reset injection at round rst_at, or the cycle budget runs out.
  task automatic run_block(input logic [255:0] hin, input logic [255:0] hexp, input bit stall,
                           input int g1, input int g2, input int rst_at,
                           output int lat, output int nstall, output int rdy_err,
                           output bit got_done, output bit busy_at_done, output bit rst_hit,
                           output int done_cyc, output logic [255:0] dig);
    int  k, t;
    bit  v, hs, exp_rdy;
    lat = 0; nstall = 0; rdy_err = 0; got_done = 0; busy_at_done = 1; rst_hit = 0;
    done_cyc = 0; dig = '0;
    start = 1'b1; hash_in = hin; w_valid = 1'b0;
    sb_q.push_back(compress(hexp));
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; t = 0;
    while (k < 400) begin
      if (done === 1'b1) begin
        got_done = 1; lat = k; dig = hash_out; busy_at_done = busy; done_cyc = cyc;
        break;
      end
      exp_rdy = (t < 64);
      if (w_ready !== exp_rdy) rdy_err++;
      if (rst_at >= 0 && t == rst_at) begin
        rst = 1'b1; w_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rst_hit = 1;
        return;
      end
      if (t == g1 || t == g2) begin start = 1'b1; hash_in = ~hin; end
      else begin start = 1'b0; hash_in = hin; end
      v = stall ? ((k % 3) != 2) : 1'b1;
      w_valid = v;
      w_data  = (v && t < 64) ? wsched[t] : $urandom;
      hs = v && (w_ready === 1'b1);
      if (!v && exp_rdy) nstall++;
      @(posedge clk); #1;
      k++;
      if (hs) t++;
    end
    w_valid = 1'b0; start = 1'b0; hash_in = hin;
  endtask

  logic [255:0] exp_dig, got_dig;
  int  lat, nstall, rdy_err, dcyc;
  bit  gd, bad, rh;

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0; hash_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %b expected 0", w_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (hash_out !== '0) begin n_err++; $display("FAIL reset_hash_out: got %h expected 0", hash_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abc(input bit stall);
    load_block(BLK_ABC);
    run_block(IV, IV, stall, -1, -1, -1, lat, nstall, rdy_err, gd, bad, rh, dcyc, got_dig);
    n_cmp++; if (gd !== 1'b1) begin n_err++; $display("FAIL abc_done_seen(stall=%0d): got %0d expected 1", stall, gd); end
    exp_dig = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_cmp++; if (got_dig !== exp_dig) begin n_err++; $display("FAIL abc_digest_sb(stall=%0d): got %h expected %h", stall, got_dig, exp_dig); end
    n_cmp++; if (got_dig !== ABC_DIG) begin n_err++; $display("FAIL abc_digest_ref(stall=%0d): got %h expected %h", stall, got_dig, ABC_DIG); end
    n_cmp++; if (lat !== 65 + nstall) begin n_err++; $display("FAIL abc_latency(stall=%0d): got %0d expected %0d", stall, lat, 65 + nstall); end
    n_cmp++; if (rdy_err !== 0) begin n_err++; $display("FAIL abc_w_ready(stall=%0d): got %0d bad cycles expected 0", stall, rdy_err); end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL abc_busy_at_done(stall=%0d): got %b expected 0", stall, bad); end
    if (stall) begin
      n_cmp++; if (nstall < 30) begin n_err++; $display("FAIL abc_stall_count: got %0d expected >=30", nstall); end
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abc_done_pulse(stall=%0d): got %b expected 0", stall, done); end
    n_cmp++; if (hash_out !== ABC_DIG) begin n_err++; $display("FAIL abc_hash_hold(stall=%0d): got %h expected %h", stall, hash_out, ABC_DIG); end
  endtask

  task automatic test_start_busy;
    int extra = 0;
    load_block(BLK_ABC);
    run_block(IV, IV, 1'b0, 10, 63, -1, lat, nstall, rdy_err, gd, bad, rh, dcyc, got_dig);
    exp_dig = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_cmp++; if (got_dig !== exp_dig) begin n_err++; $display("FAIL busy_start_digest: got %h expected %h", got_dig, exp_dig); end
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 65", lat); end
    repeat (80) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL busy_start_extra_activity: got %0d cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int extra = 0;
    load_block(BLK_ABC);
    run_block(IV, IV, 1'b0, -1, -1, 30, lat, nstall, rdy_err, gd, bad, rh, dcyc, got_dig);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    n_cmp++; if (rh !== 1'b1) begin n_err++; $display("FAIL rstmid_reached: got %0d expected 1", rh); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_w_ready: got %b expected 0", w_ready); end
    n_cmp++; if (hash_out !== '0) begin n_err++; $display("FAIL rstmid_hash_out: got %h expected 0", hash_out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b expected 0", done); end
    repeat (70) begin
      w_valid = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    w_valid = 1'b0;
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d done cycles expected 0", extra); end
    test_abc(1'b0);
  endtask

  task automatic test_back_to_back;
    logic [255:0] d1, exp1;
    int c1;
    load_block(BLK_2A);
    run_block(IV, IV, 1'b0, -1, -1, -1, lat, nstall, rdy_err, gd, bad, rh, c1, d1);
    exp1 = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_cmp++; if (d1 !== exp1) begin n_err++; $display("FAIL b2b_block1: got %h expected %h", d1, exp1); end
    load_block(BLK_2B);
    run_block(d1, exp1, 1'b0, -1, -1, -1, lat, nstall, rdy_err, gd, bad, rh, dcyc, got_dig);
    exp_dig = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_cmp++; if (got_dig !== exp_dig) begin n_err++; $display("FAIL b2b_block2_sb: got %h expected %h", got_dig, exp_dig); end
    n_cmp++; if (got_dig !== TWO_DIG) begin n_err++; $display("FAIL b2b_block2_ref: got %h expected %h", got_dig, TWO_DIG); end
    n_cmp++; if (dcyc - c1 !== 66) begin n_err++; $display("FAIL b2b_period: got %0d expected 66", dcyc - c1); end
    @(posedge clk); #1;
  endtask

  task automatic test_collision;
    int act = 0;
    rst = 1'b1; start = 1'b1; hash_in = IV;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL collide_busy: got %b expected 0", busy); end
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL collide_w_ready: got %b expected 0", w_ready); end
    repeat (5) begin
      w_valid = 1'b1;
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) act++;
    end
    w_valid = 1'b0;
    n_cmp++; if (act !== 0) begin n_err++; $display("FAIL collide_idle: got %0d active cycles expected 0", act); end
  endtask

  initial begin
    test_reset();
    test_abc(1'b0);
    test_abc(1'b1);
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression function. It latches a 256-bit chaining value and runs the 64-round compression loop over working variables a..h. Each round consumes one message-schedule word Wt through a valid/ready handshake, so rounds advance only when a word is supplied. The block holds the 64-entry K constant ROM and instantiates `usigma0` (Σ0) and `usigma1` (Σ1) for the round datapath. It sits between the message scheduler (Wt producer) and the top-level hash controller (start/digest consumer).

## Interface
Parameters: none (64 rounds and 32-bit words are fixed by FIPS 180-4).

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin compression. Sampled only in IDLE; ignored otherwise.
- `hash_in` in 256: chaining value H0..H7, with [255:224] = H0 and [31:0] = H7. Latched on an accepted `start`.
- `w_valid` in 1: `w_data` carries Wt for the current round.
- `w_data` in 32: message-schedule word Wt.
- `w_ready` out 1: high only in ROUND. A word transfers when `w_valid && w_ready`.
- `busy` out 1: high in ROUND and FINAL.
- `done` out 1: one-cycle registered pulse; `hash_out` is valid from that cycle.
- `hash_out` out 256: H'0..H'7, same packing as `hash_in`. Held until the next FINAL.

## Operation
- States: IDLE, ROUND, FINAL.
- **IDLE**
  - On `start`: latch `hash_in` into H0..H7 and into a..h.
  - Set round counter t = 0 (6 bits). Go to ROUND.
- **ROUND**
  - Each handshake cycle computes:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt
    - T2 = Σ0(a) + Maj(a,b,c)
    - Σ0 = rotr 2^13^22 of a; Σ1 = rotr 6^11^25 of e.
    - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - All additions are mod 2^32; carries are discarded.
  - Register update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2, t←t+1.
  - No handshake (`w_valid` = 0): a..h and t hold.
  - Handshake at t = 63: go to FINAL; t wraps to 0.
- **FINAL**
  - For each i, `hash_out` word i ← Hi + working variable i (a..h), mod 2^32.
  - `done` ← 1 for one cycle; go to IDLE.
- K ROM: the FIPS 180-4 constants K[0] = 428a2f98 … K[63] = c67178f2, indexed by t.
- Reset (any state, including mid-round):
  - state = IDLE, t = 0.
  - a..h, H0..H7 and `hash_out` = 0.
  - `done` = 0, `busy` = 0, `w_ready` = 0.
  - A partial compression is discarded without a `done`.
- `start` and `rst` in the same cycle: `rst` wins.
- `start` while `busy`: ignored; no effect on state or outputs.
- `start` in the cycle `done` is high: accepted (state is IDLE), which allows back-to-back blocks.

## Timing
- Let edge E0 be the edge that accepts `start`.
- `w_ready` and `busy` rise after E0.
- With `w_valid` held high, rounds 0..63 complete at edges E1..E64. `w_ready` falls after E64.
- FINAL occupies the cycle after E64. E65 registers `hash_out`; `done` is high for the cycle after E65.
- Start-to-done latency is 65 cycles plus the number of ROUND cycles with `w_valid` = 0.
- `busy` falls with `done` high.
- Minimum block period with a `start` on every `done`: 66 cycles.
- `w_data` is used only in handshake cycles and need not be stable otherwise.

## Test plan
- **Single block "abc"**
  - Stimulus: `hash_in` = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19. W0 = 61626380, W1..W14 = 0, W15 = 00000018; W16..W63 from the reference model; `w_valid` constant.
  - Required: `done` 65 cycles after the start edge.
  - Required: `hash_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Stalls**
  - Stimulus: same as the "abc" case, with `w_valid` low for 1 cycle every 3rd cycle (about 32 stall cycles).
  - Required: identical digest; latency = 65 + number of stall cycles.
  - Required: `w_ready` stays high throughout ROUND.
- **Start while busy**
  - Stimulus: pulse `start` at rounds 10 and 63 with a different `hash_in`.
  - Required: ignored; digest unchanged; exactly one `done`.
- **Reset mid-operation**
  - Stimulus: assert `rst` for 1 cycle at round 30.
  - Required: next cycle `busy` = 0, `w_ready` = 0, `hash_out` = 0, no `done`.
  - Required: a following "abc" run yields the correct digest.
- **Two-block chaining**
  - Stimulus: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". Second `start` in the `done` cycle of block 1, with `hash_in` = block-1 `hash_out`.
  - Required: final `hash_out` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Required: period between the two `done` pulses = 66 cycles.
- **Reset/start collision**
  - Stimulus: `rst` and `start` high in the same cycle.
  - Required: stays IDLE, `busy` = 0.
